arm_hps_key_event_ctrl: RTL



---
 rtl/arm_hps_key_pkg.sv | 41 ++++
 rtl/arm_hps_key_debounce.sv | 87 ++++++++
 rtl/arm_hps_key_event_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/arm_hps_key_pkg.sv
// Shared constants and the event record for the push-button event controller.
package arm_hps_key_pkg;

  localparam logic [1:0] ADDR_STATE = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_FIFO  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  localparam int EVT_W        = 4;
  localparam int EVT_IDX_LSB  = 0;
  localparam int EVT_IDX_W    = 2;
  localparam int EVT_TYPE_BIT = 2;
  localparam int EVT_REP_BIT  = 3;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  localparam int RD_VALID_BIT = 31;
  localparam int RD_OVF_BIT   = 30;
  localparam int RD_COUNT_LSB = 8;
  localparam int RD_COUNT_W   = 5;

  typedef struct packed {
    logic       rep;
    logic       kind;
    logic [1:0] idx;
  } key_event_t;

  function automatic logic [31:0] fifo_status_word(input logic valid, input logic ovf,
                                                   input logic [RD_COUNT_W-1:0] count,
                                                   input key_event_t head);
    logic [31:0] word;
    word = 32'd0;
    word[RD_VALID_BIT] = valid;
    word[RD_OVF_BIT] = ovf;
    word[RD_COUNT_LSB +: RD_COUNT_W] = count;
    word[EVT_W-1:0] = valid ? head : 4'd0;
    return word;
  endfunction

endpackage

// File: rtl/arm_hps_key_debounce.sv
// Per-key synchroniser and debouncer; optional auto-repeat timer (KEY_AUTOREPEAT_EN).
module arm_hps_key_debounce
  import arm_hps_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
`ifdef KEY_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 25000000
  , parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic rep
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             toggle_s;

  // Edge pulses coincide with the stable-state flip so captures land on the same clock.
  assign toggle_s = (sync2_r != stable_r) && (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise     = toggle_s & ~stable_r;
  assign fall     = toggle_s & stable_r;
  assign stable   = stable_r;

  // Synchroniser, stability counter and accepted key level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= key_raw;
      sync2_r <= sync1_r;
      if (sync2_r == stable_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (toggle_s) begin
        cnt_r    <= {CNT_W{1'b0}};
        stable_r <= ~stable_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX) + 1;

  logic [REP_W-1:0] rep_cnt_r;
  logic             rep_first_r;
  logic [REP_W-1:0] rep_limit_s;
  logic             rep_hit_s;

  assign rep_limit_s = rep_first_r ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
  assign rep_hit_s   = stable_r & ~toggle_s & (rep_cnt_r == rep_limit_s);
  assign rep         = rep_hit_s;

  // Repeat timer: runs only while the key is stably pressed, restarts on every press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt_r   <= {REP_W{1'b0}};
      rep_first_r <= 1'b0;
    end else if (~stable_r | toggle_s) begin
      rep_cnt_r   <= {REP_W{1'b0}};
      rep_first_r <= 1'b1;
    end else if (rep_hit_s) begin
      rep_cnt_r   <= {REP_W{1'b0}};
      rep_first_r <= 1'b0;
    end else begin
      rep_cnt_r <= rep_cnt_r + REP_W'(1);
    end
  end
`else
  assign rep = 1'b0;
`endif

endmodule

// File: rtl/arm_hps_key_event_ctrl.sv
// Avalon-MM key controller: debounced state, edge capture, irq mask and event FIFO.
// Optional auto-repeat events are enabled by defining KEY_AUTOREPEAT_EN.
module arm_hps_key_event_ctrl
  import arm_hps_key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 8
`ifdef KEY_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 25000000
  , parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                read_n,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_KEYS-1:0] in_port,
  output logic                irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_KEYS-1:0] stable_s, rise_s, fall_s, rep_s;
  logic [NUM_KEYS-1:0] pend_r, pend_kind_r, pend_rep_r;
  logic [NUM_KEYS-1:0] edge_r, clr_s;
  logic [4:0]          mask_r;
  logic                ovf_r;
  logic [31:0]         readdata_r, rd_word_s;
  logic                irq_r;
  key_event_t          mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [1:0]          grant_s;
  logic                push_s, push_ok_s, pop_s, drop_s;
  logic                rd_en_s, wr_en_s, fifo_valid_s, full_s;
  key_event_t          push_evt_s;
  logic                unused_s;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    arm_hps_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      , .REPEAT_DELAY(REPEAT_DELAY)
      , .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .key_raw(in_port[g]),
      .stable (stable_s[g]),
      .rise   (rise_s[g]),
      .fall   (fall_s[g]),
      .rep    (rep_s[g])
    );
  end

  assign rd_en_s      = chipselect & ~read_n;
  assign wr_en_s      = chipselect & ~write_n;
  assign fifo_valid_s = (count_r != CNT_W'(0));
  assign full_s       = (count_r == CNT_W'(FIFO_DEPTH));
  assign pop_s        = rd_en_s & (address == ADDR_FIFO) & fifo_valid_s;
  assign push_ok_s    = push_s & (~full_s | pop_s);
  assign drop_s       = push_s & full_s & ~pop_s;
  assign unused_s     = ^writedata[31:5];

  // Fixed-priority arbiter: lowest pending key index gets the single push slot.
  always_comb begin
    grant_s = 2'd0;
    push_s  = 1'b0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pend_r[k]) begin
        grant_s = k[1:0];
        push_s  = 1'b1;
      end else begin
        push_s = push_s;
      end
    end
    push_evt_s.rep  = pend_rep_r[grant_s];
    push_evt_s.kind = pend_kind_r[grant_s];
    push_evt_s.idx  = grant_s;
  end

  // Pending event flags per key; a fresh edge outranks clearing by a grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_r      <= {NUM_KEYS{1'b0}};
      pend_kind_r <= {NUM_KEYS{1'b0}};
      pend_rep_r  <= {NUM_KEYS{1'b0}};
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (rise_s[k] | fall_s[k] | rep_s[k]) begin
          pend_r[k]      <= 1'b1;
          pend_kind_r[k] <= (rise_s[k] | rep_s[k]) ? EVT_PRESS : EVT_RELEASE;
          pend_rep_r[k]  <= rep_s[k];
        end else if (push_s && (grant_s == k[1:0])) begin
          pend_r[k] <= 1'b0;
        end
      end
    end
  end

  // Event FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 4'd0;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_evt_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) ovf_r <= 1'b1;
      else if (wr_en_s && (address == ADDR_FIFO)) ovf_r <= 1'b0;
    end
  end

  // Read mux and write-1-to-clear decode.
  always_comb begin
    rd_word_s = 32'd0;
    clr_s     = {NUM_KEYS{1'b0}};
    case (address)
      ADDR_STATE: rd_word_s[NUM_KEYS-1:0] = stable_s;
      ADDR_MASK:  rd_word_s[4:0] = mask_r;
      ADDR_FIFO:  rd_word_s = fifo_status_word(fifo_valid_s, ovf_r, RD_COUNT_W'(count_r),
                                               mem_r[rd_ptr_r]);
      ADDR_EDGE:  rd_word_s[NUM_KEYS-1:0] = edge_r;
      default:    rd_word_s = 32'd0;
    endcase
    if (wr_en_s && (address == ADDR_EDGE)) clr_s = writedata[NUM_KEYS-1:0];
    else clr_s = {NUM_KEYS{1'b0}};
  end

  // Register file, registered read data and level interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_r     <= {NUM_KEYS{1'b0}};
      mask_r     <= 5'd0;
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      edge_r <= (edge_r & ~clr_s) | rise_s;
      if (wr_en_s && (address == ADDR_MASK)) mask_r <= writedata[4:0];
      if (rd_en_s) readdata_r <= rd_word_s;
      irq_r <= (|(edge_r & mask_r[NUM_KEYS-1:0])) | (mask_r[4] & fifo_valid_s);
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;

endmodule
